// File: rtl/sd_emmc_cmd_phy.sv
// CMD-line serializer/deserializer for one SD/eMMC device: sends a 48-bit command with CRC7 and checks the response.
// Optional macro SD_EMMC_CMD_NCR_TIMEOUT_EN: give up after 64 idle cycles waiting for a response start bit.
module sd_emmc_cmd_phy #(
  parameter int unsigned NCC_CYCLES = 8,
  parameter int unsigned CRC_W      = 7
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         go_idle_i,
  input  logic [1:0]   setting_i,
  input  logic [39:0]  cmd_i,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic [119:0] response_o,
  output logic         crc_ok_o,
  output logic         index_ok_o,
  output logic         finish_o,
  output logic         busy_o
);

  localparam int unsigned CMD_W = 40;
  localparam int unsigned RSP_W = 120;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned NCC_W = $clog2(NCC_CYCLES) + 1;
  localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(9);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT_RSP, S_RX, S_NCC} state_t;

  state_t             r_state;
  logic [CMD_W-1:0]   r_tx;
  logic [IDX_W-1:0]   r_cmd_idx;
  logic               r_long;
  logic               r_expect;
  logic [CNT_W-1:0]   r_cnt;
  logic [NCC_W-1:0]   r_ncc;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   r_rcrc;
  logic [IDX_W-1:0]   r_idx;
  logic [RSP_W-1:0]   r_sh;
  logic               r_out;
  logic               r_oe;
  logic [RSP_W-1:0]   r_rsp;
  logic               r_crc_ok;
  logic               r_idx_ok;
  logic               r_finish;
  logic               r_busy;

  logic [CRC_W-1:0]   w_crc_tx;
  logic [CNT_W-1:0]   w_last;
  logic [CNT_W-1:0]   w_pay_hi;
  logic [CNT_W-1:0]   w_crc_lo;
  logic               w_in_crc;
  logic               w_in_idx;
  logic               w_in_pay;
  logic               w_in_rcrc;
  logic               w_idx_ok;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    crc_step = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
  endfunction

  // RX bit windows, indexed by bits received after the start bit
  assign w_crc_tx  = crc_step(r_crc, r_out);
  assign w_last    = r_long ? 8'd134 : 8'd46;
  assign w_pay_hi  = r_long ? 8'd126 : 8'd38;
  assign w_crc_lo  = r_long ? 8'd7   : 8'd0;
  assign w_in_crc  = (r_cnt >= w_crc_lo) && (r_cnt <= w_pay_hi);
  assign w_in_idx  = (r_cnt >= 8'd1) && (r_cnt <= 8'd6);
  assign w_in_pay  = (r_cnt >= 8'd7) && (r_cnt <= w_pay_hi);
  assign w_in_rcrc = (r_cnt > w_pay_hi) && (r_cnt < w_last);
  assign w_idx_ok  = r_long ? (r_idx == '1) : (r_idx == r_cmd_idx);

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= '0;
      r_cmd_idx <= '0;
      r_long    <= 1'b0;
      r_expect  <= 1'b0;
      r_cnt     <= '0;
      r_ncc     <= '0;
      r_crc     <= '0;
      r_rcrc    <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      r_out     <= 1'b1;
      r_oe      <= 1'b0;
      r_rsp     <= '0;
      r_crc_ok  <= 1'b0;
      r_idx_ok  <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (go_idle_i) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_out   <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_tx      <= cmd_i;
              r_cmd_idx <= cmd_i[37:32];
              r_long    <= setting_i[1];
              r_expect  <= setting_i[0];
              r_crc     <= '0;
              r_cnt     <= '0;
              r_out     <= cmd_i[CMD_W-1];
              r_oe      <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_TX;
            end
          end
          // r_cnt is the index of the bit currently on the line
          S_TX: begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt < 8'd39) begin
              r_crc <= w_crc_tx;
              r_tx  <= r_tx << 1;
              r_out <= r_tx[CMD_W-2];
            end else if (r_cnt == 8'd39) begin
              r_crc <= w_crc_tx;
              r_out <= w_crc_tx[CRC_W-1];
            end else if (r_cnt < 8'd46) begin
              r_crc <= r_crc << 1;
              r_out <= r_crc[CRC_W-2];
            end else if (r_cnt == 8'd46) begin
              r_out <= 1'b1;
            end else begin
              r_oe    <= 1'b0;
              r_out   <= 1'b1;
              r_cnt   <= '0;
              r_ncc   <= '0;
              r_state <= r_expect ? S_WAIT_RSP : S_NCC;
            end
          end
          // A zero start bit leaves a cleared CRC unchanged, so clearing here covers it
          S_WAIT_RSP: begin
            if (!cmd_dat_i) begin
              r_state <= S_RX;
              r_cnt   <= '0;
              r_crc   <= '0;
            end
`ifdef SD_EMMC_CMD_NCR_TIMEOUT_EN
            else if (r_cnt == 8'd63) begin
              r_finish <= 1'b1;
              r_crc_ok <= 1'b0;
              r_idx_ok <= 1'b0;
              r_rsp    <= '0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
`else
            else begin
              r_state <= S_WAIT_RSP;
            end
`endif
          end
          S_RX: begin
            r_cnt <= r_cnt + 8'd1;
            if (w_in_crc)  r_crc  <= crc_step(r_crc, cmd_dat_i);
            if (w_in_idx)  r_idx  <= {r_idx[IDX_W-2:0], cmd_dat_i};
            if (w_in_pay)  r_sh   <= {r_sh[RSP_W-2:0], cmd_dat_i};
            if (w_in_rcrc) r_rcrc <= {r_rcrc[CRC_W-2:0], cmd_dat_i};
            if (r_cnt == w_last) begin
              r_finish <= 1'b1;
              r_crc_ok <= (r_crc == r_rcrc) && cmd_dat_i;
              r_idx_ok <= w_idx_ok;
              r_rsp    <= r_long ? r_sh : {r_sh[31:0], 88'd0};
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          S_NCC: begin
            if (r_ncc == NCC_W'(NCC_CYCLES - 1)) begin
              r_finish <= 1'b1;
              r_crc_ok <= 1'b1;
              r_idx_ok <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_ncc <= r_ncc + NCC_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_out_o  = r_out;
  assign cmd_oe_o   = r_oe;
  assign response_o = r_rsp;
  assign crc_ok_o   = r_crc_ok;
  assign index_ok_o = r_idx_ok;
  assign finish_o   = r_finish;
  assign busy_o     = r_busy;

endmodule
